// File: rtl/motor_pkg.sv
// Shared types and helpers for the dual-motor PWM driver: direction and
// channel-state enums, the PWM period top and command decoding.
package motor_pkg;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_FWD  = 2'd1,
    DIR_REV  = 2'd2
  } dir_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DEAD = 1'b1
  } ch_state_e;

  localparam int unsigned PWM_TOP = 254;
  localparam int          CMD_W   = 8;

  // |cmd| with -128 saturated to 127, so doubled duty never exceeds PWM_TOP.
  function automatic logic [6:0] cmd_to_mag(input logic [CMD_W-1:0] cmd);
    logic [CMD_W-1:0] abs_v;
    if (cmd[7] && (cmd[6:0] == 7'd0)) begin
      return 7'd127;
    end
    abs_v = cmd[7] ? (~cmd + 8'd1) : cmd;
    return abs_v[6:0];
  endfunction

  function automatic dir_e cmd_to_dir(input logic [CMD_W-1:0] cmd);
    if (cmd == 8'd0) begin
      return DIR_NONE;
    end
    return cmd[7] ? DIR_REV : DIR_FWD;
  endfunction

endpackage

// File: rtl/motor_pwm_driver_channel.sv
// One H-bridge channel: pending command, run/dead-time FSM, boundary-aligned
// duty/direction registers and registered PWM enable plus direction lines.
module pwm_channel
  import motor_pkg::*;
#(
  parameter int unsigned DEADTIME_PERIODS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid_i,
  input  logic [CMD_W-1:0] cmd_i,
  input  logic [7:0]       count_i,
  input  logic             boundary_i,
  input  logic             force_coast_i,
  output logic             en_o,
  output logic             dir_a_o,
  output logic             dir_b_o
);

  localparam int DEAD_W = (DEADTIME_PERIODS > 1) ? $clog2(DEADTIME_PERIODS + 1) : 1;

  logic [CMD_W-1:0]  pending_q, pending_d;
  logic [CMD_W-1:0]  eff_cmd;
  ch_state_e         state_q, state_d;
  dir_e              dir_q, dir_d, new_dir;
  logic [7:0]        duty_q, duty_d, new_duty;
  logic [DEAD_W-1:0] dead_q, dead_d;
  logic              apply;
  logic              en_q, en_d;
  logic              dir_a_q, dir_a_d;
  logic              dir_b_q, dir_b_d;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      state_q   <= ST_RUN;
      dir_q     <= DIR_NONE;
      duty_q    <= '0;
      dead_q    <= '0;
      en_q      <= 1'b0;
      dir_a_q   <= 1'b0;
      dir_b_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values,
      // independent of statement order.
      pending_q <= pending_d;
      state_q   <= state_d;
      dir_q     <= dir_d;
      duty_q    <= duty_d;
      dead_q    <= dead_d;
      en_q      <= en_d;
      dir_a_q   <= dir_a_d;
      dir_b_q   <= dir_b_d;
    end
  end

  // Next-state logic; a command arriving on the boundary cycle is used directly.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch is inferred.
    eff_cmd   = cmd_valid_i ? cmd_i : pending_q;
    new_dir   = cmd_to_dir(eff_cmd);
    new_duty  = {cmd_to_mag(eff_cmd), 1'b0};
    pending_d = eff_cmd;
    state_d   = state_q;
    dir_d     = dir_q;
    duty_d    = duty_q;
    dead_d    = dead_q;
    apply     = 1'b0;

    if (force_coast_i) begin
      pending_d = '0;
      state_d   = ST_RUN;
      dir_d     = DIR_NONE;
      duty_d    = '0;
      dead_d    = '0;
    end else if (boundary_i) begin
      case (state_q)
        ST_RUN: begin
          if ((new_dir == dir_q) || (new_dir == DIR_NONE) || (dir_q == DIR_NONE)) begin
            apply = 1'b1;
          end else begin
            state_d = ST_DEAD;
            dead_d  = DEAD_W'(DEADTIME_PERIODS);
          end
        end
        ST_DEAD: begin
          // Last dead period ends here; whatever is pending now takes effect.
          if (dead_q == DEAD_W'(1)) begin
            apply = 1'b1;
          end else begin
            dead_d = dead_q - DEAD_W'(1);
          end
        end
      endcase

      if (apply) begin
        state_d = ST_RUN;
        dir_d   = new_dir;
        duty_d  = new_duty;
        dead_d  = '0;
      end
    end
  end

  // Output decode; the bridge is only driven while running in a real direction.
  always_comb begin
    en_d    = 1'b0;
    dir_a_d = 1'b0;
    dir_b_d = 1'b0;
    if ((state_q == ST_RUN) && (dir_q != DIR_NONE)) begin
      en_d    = (count_i < duty_q);
      dir_a_d = (dir_q == DIR_FWD);
      dir_b_d = (dir_q == DIR_REV);
    end
  end

  assign en_o    = en_q;
  assign dir_a_o = dir_a_q;
  assign dir_b_o = dir_b_q;

endmodule

// File: rtl/motor_pwm_driver.sv
// Dual-motor PWM driver: shared prescaler, 0..254 period counter and command
// watchdog feeding two pwm_channel instances.
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int unsigned PRESCALE         = 47,
  parameter int unsigned DEADTIME_PERIODS = 2,
  parameter int unsigned WDT_PERIODS      = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [CMD_W-1:0] motor1_cmd,
  input  logic [CMD_W-1:0] motor2_cmd,
  output logic             enable12,
  output logic             enable34,
  output logic             a1,
  output logic             a2,
  output logic             a3,
  output logic             a4,
  output logic             timeout
);

  localparam int PRE_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam int WDT_W = (WDT_PERIODS > 0) ? $clog2(WDT_PERIODS + 1) : 1;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [7:0]       count_q, count_d;
  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic             timeout_q, timeout_d;
  logic             tick;
  logic             boundary;
  logic             wdt_expire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q     <= '0;
      count_q   <= '0;
      wdt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      count_q   <= count_d;
      wdt_q     <= wdt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    tick     = (pre_q == PRE_W'(PRESCALE));
    pre_d    = tick ? '0 : pre_q + PRE_W'(1);
    boundary = tick && (count_q == 8'(PWM_TOP));
    count_d  = count_q;
    if (tick) begin
      count_d = boundary ? 8'd0 : count_q + 8'd1;
    end
  end

  // Watchdog counts boundaries since the last command and saturates at the
  // limit; a command on the expiry cycle takes priority.
  always_comb begin
    wdt_d      = wdt_q;
    timeout_d  = timeout_q;
    wdt_expire = 1'b0;
    if (cmd_valid) begin
      wdt_d     = '0;
      timeout_d = 1'b0;
    end else if ((WDT_PERIODS != 0) && boundary && (wdt_q != WDT_W'(WDT_PERIODS))) begin
      wdt_d = wdt_q + WDT_W'(1);
      if (wdt_q == WDT_W'(WDT_PERIODS - 1)) begin
        wdt_expire = 1'b1;
        timeout_d  = 1'b1;
      end
    end
  end

  assign timeout = timeout_q;

  pwm_channel #(
    .DEADTIME_PERIODS(DEADTIME_PERIODS)
  ) u_ch1 (
    .clk          (clk),
    .rst_n        (reset),
    .cmd_valid_i  (cmd_valid),
    .cmd_i        (motor1_cmd),
    .count_i      (count_q),
    .boundary_i   (boundary),
    .force_coast_i(wdt_expire),
    .en_o         (enable12),
    .dir_a_o      (a1),
    .dir_b_o      (a2)
  );

  pwm_channel #(
    .DEADTIME_PERIODS(DEADTIME_PERIODS)
  ) u_ch2 (
    .clk          (clk),
    .rst_n        (reset),
    .cmd_valid_i  (cmd_valid),
    .cmd_i        (motor2_cmd),
    .count_i      (count_q),
    .boundary_i   (boundary),
    .force_coast_i(wdt_expire),
    .en_o         (enable34),
    .dir_a_o      (a3),
    .dir_b_o      (a4)
  );

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Scoreboard bench for motor_pwm_driver: stimulus queues per-period expectations,
// a monitor measures each PWM period at the pins and compares.
`timescale 1ns/1ps
module tb_motor_pwm_driver;

  localparam int PER = 255;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] motor1_cmd = 8'd0;
  logic [7:0] motor2_cmd = 8'd0;
  logic       enable12, enable34, a1, a2, a3, a4, timeout;

  int checks = 0;
  int errors = 0;
  int cyc;

  typedef struct {
    int         period;
    int         en12;
    int         en34;
    logic [3:0] dirs;
    logic       tmo;
  } exp_t;

  exp_t sb[$];

  motor_pwm_driver #(
    .PRESCALE        (0),
    .DEADTIME_PERIODS(2),
    .WDT_PERIODS     (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .motor1_cmd(motor1_cmd),
    .motor2_cmd(motor2_cmd),
    .enable12  (enable12),
    .enable34  (enable34),
    .a1        (a1),
    .a2        (a2),
    .a3        (a3),
    .a4        (a4),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Edge index since reset release: after edge k the pins show count (k-1) mod 255.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_p(input int p, input int e12, input int e34,
                          input logic [3:0] d, input logic t);
    exp_t e;
    e = '{p, e12, e34, d, t};
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Drive a one-cycle cmd_valid so the DUT samples it at edge at_edge.
  task automatic send(input logic [7:0] m1, input logic [7:0] m2, input int at_edge);
    wait_cyc(at_edge - 1);
    if (cyc != at_edge - 1) begin
      checks++;
      errors++;
      $display("FAIL send_schedule: at edge %0d wanted %0d", cyc, at_edge - 1);
    end
    cmd_valid  = 1'b1;
    motor1_cmd = m1;
    motor2_cmd = m2;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Monitor: one record per completed PWM period at the pins.
  int         idx, pnum, hi12, hi34;
  logic [3:0] dirs0;
  logic       tmo0, stable, pre12, pre34, low12, low34;
  exp_t       e;

  always @(negedge clk) begin
    if (reset && cyc >= 1) begin
      idx  = (cyc - 1) % PER;
      pnum = (cyc - 1) / PER;
      if (idx == 0) begin
        hi12 = 0; hi34 = 0;
        dirs0 = {a1, a2, a3, a4};
        tmo0 = timeout;
        stable = 1'b1; pre12 = 1'b1; pre34 = 1'b1; low12 = 1'b0; low34 = 1'b0;
      end
      if (enable12) begin hi12++; if (low12) pre12 = 1'b0; end else low12 = 1'b1;
      if (enable34) begin hi34++; if (low34) pre34 = 1'b0; end else low34 = 1'b1;
      if ({a1, a2, a3, a4} !== dirs0) stable = 1'b0;
      if (idx == PER - 1) begin
        while (sb.size() > 0 && sb[0].period < pnum) begin
          checks++;
          errors++;
          $display("FAIL sb_missed: period %0d never observed, now at %0d", sb[0].period, pnum);
          void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].period == pnum) begin
          e = sb.pop_front();
          check($sformatf("p%0d_en12_high", pnum), hi12, e.en12);
          check($sformatf("p%0d_en34_high", pnum), hi34, e.en34);
          check($sformatf("p%0d_dirs_a1a2a3a4", pnum), int'(dirs0), int'(e.dirs));
          check($sformatf("p%0d_timeout", pnum), int'(tmo0), int'(e.tmo));
          check($sformatf("p%0d_glitch_free", pnum), int'({stable, pre12, pre34}), 7);
        end
      end
    end
  end

  initial begin
    #400us;
    $display("FAIL global_time_limit: stimulus did not complete, at edge %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    // Reset asserted mid-period.
    repeat (3) @(negedge clk);
    reset = 1'b1;
    expect_p(0, 0, 0, 4'b0000, 1'b0);
    expect_p(1, 200, 0, 4'b1000, 1'b0);
    send(8'd100, 8'd0, 100);
    wait_cyc(2 * PER + 77);
    check("pre_reset_enable12", int'(enable12), 1);
    check("pre_reset_a1", int'(a1), 1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_outputs", int'({enable12, enable34, a1, a2, a3, a4, timeout}), 0);
    check("sb_empty_at_reset", sb.size(), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Idle after reset, then fwd 100 / rev -50.
    expect_p(0, 0, 0, 4'b0000, 1'b0);
    expect_p(1, 0, 0, 4'b0000, 1'b0);
    expect_p(2, 200, 100, 4'b1001, 1'b0);
    expect_p(3, 200, 100, 4'b1001, 1'b0);
    send(8'd100, 8'hCE, 2 * PER - 50);

    // Reversal on motor 1: two dead periods, motor 2 untouched.
    expect_p(4, 0, 100, 4'b0001, 1'b0);
    expect_p(5, 0, 100, 4'b0001, 1'b0);
    expect_p(6, 200, 100, 4'b0101, 1'b0);
    expect_p(7, 200, 100, 4'b0101, 1'b0);
    send(8'h9C, 8'hCE, 4 * PER - 50);

    // -128 saturates to duty 254; then +1 (reversal again) gives duty 2; then 0.
    expect_p(8, 254, 100, 4'b0101, 1'b0);
    send(8'h80, 8'hCE, 8 * PER - 50);
    expect_p(9, 0, 100, 4'b0001, 1'b0);
    expect_p(10, 0, 100, 4'b0001, 1'b0);
    expect_p(11, 2, 100, 4'b1001, 1'b0);
    send(8'd1, 8'hCE, 9 * PER - 50);
    expect_p(12, 0, 100, 4'b0001, 1'b0);
    expect_p(15, 0, 100, 4'b0001, 1'b0);
    expect_p(18, 0, 100, 4'b0001, 1'b0);
    expect_p(19, 0, 0, 4'b0000, 1'b1);
    expect_p(20, 0, 0, 4'b0000, 1'b1);
    send(8'd0, 8'hCE, 12 * PER - 50);

    // Watchdog: last command sampled in period 11, expiry at the 8th boundary.
    wait_cyc(19 * PER - 1);
    check("wdt_not_yet", int'(timeout), 0);
    @(negedge clk);
    check("wdt_expired", int'(timeout), 1);
    @(negedge clk);
    check("wdt_coast_outputs", int'({enable12, enable34, a1, a2, a3, a4}), 0);

    // Recovery command mid-period.
    expect_p(21, 20, 100, 4'b1010, 1'b0);
    expect_p(24, 20, 100, 4'b1010, 1'b0);
    expect_p(27, 20, 100, 4'b1010, 1'b0);
    wait_cyc(20 * PER + 99);
    check("timeout_held", int'(timeout), 1);
    send(8'd10, 8'd50, 20 * PER + 100);
    check("timeout_clear_next_clk", int'(timeout), 0);

    // Command on a boundary that is also the watchdog expiry cycle: bypass + cmd wins.
    expect_p(28, 20, 120, 4'b1010, 1'b0);
    send(8'd10, 8'd60, 28 * PER);
    check("cmd_beats_expiry", int'(timeout), 0);

    // Mid-period change: period 28 finishes at 120, period 29 uses 60.
    expect_p(29, 20, 60, 4'b1010, 1'b0);
    send(8'd10, 8'd30, 28 * PER + 100);

    wait_cyc(30 * PER + 5);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/motor_pwm_driver.md
Name: motor_pwm_driver

Overview:
Downstream consumer of pwm_spi. Takes the two 8-bit motor commands latched by the SPI receiver and generates glitch-free PWM enables (enable12, enable34) and H-bridge direction lines (a1..a4) for the dual-motor driver. It enforces dead-time on direction reversal and a command watchdog that coasts both motors if the MCU stops sending.

Parameters:
PRESCALE, 47, clk cycles per PWM tick minus 1 (48 MHz / 48 = 1 MHz tick, ~3.9 kHz PWM)
DEADTIME_PERIODS, 2, full PWM periods with bridge off on a direction reversal (min 1)
WDT_PERIODS, 1024, PWM periods without cmd_valid before forced coast; 0 disables the watchdog

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  single-clk pulse; motor1_cmd/motor2_cmd valid this cycle (already synchronised to clk)
motor1_cmd  input  8  signed two's-complement command, motor 1
motor2_cmd  input  8  signed two's-complement command, motor 2
enable12  output  1  PWM enable, motor 1
enable34  output  1  PWM enable, motor 2
a1, a2  output  1 each  motor 1 direction (fwd: a1=1,a2=0; rev: a1=0,a2=1; coast: 0,0)
a3, a4  output  1 each  motor 2 direction (same encoding)
timeout  output  1  watchdog expired; high until next cmd_valid

Behaviour:
- Reset (reset=0, async): all outputs 0; prescaler, period counter and watchdog at 0; pending commands 0; both channels ST_RUN, DIR_NONE, duty 0.
- Tick: prescaler counts 0..PRESCALE and emits a 1-clk tick at PRESCALE. Period counter advances on each tick over 0..254, then wraps. A boundary is the tick on which the counter wraps 254->0.
- Command capture: cmd_valid writes pending1/pending2. A cmd_valid on the same cycle as a boundary is used by that boundary (bypass).
- Magnitude: mag = |cmd|, with -128 saturating to 127. duty = {mag,1'b0}, range 0..254. Direction = FWD if cmd>0, REV if cmd<0, NONE if cmd==0.
- PWM output: enable = (count < duty_active) while in ST_RUN and dir != NONE; otherwise 0. Outputs are registered, so there is 1 clk of latency from count to pin.
- duty_active and dir_active change only at a boundary. No mid-period glitches.
- Per-channel FSM, evaluated at each boundary:
  - ST_RUN, new dir == dir_active or either dir is NONE: apply the new dir and duty; stay in ST_RUN.
  - ST_RUN, new dir is the opposite non-NONE dir: enable=0, direction lines=0,0, dead counter=DEADTIME_PERIODS; go to ST_DEAD.
  - ST_DEAD: decrement at each boundary. At 0, apply the latest pending (dir and duty, whatever they are now) and go to ST_RUN. A pending that returns to the original dir is applied without further dead-time.
- Command latency: from cmd_valid to a new duty at the pins is at most 255*(PRESCALE+1)+2 clk, plus DEADTIME_PERIODS periods on a reversal.
- Watchdog:
  - Counts boundaries and is cleared by cmd_valid.
  - On reaching WDT_PERIODS: timeout=1, pending1/2 cleared to 0, both channels forced to ST_RUN/DIR_NONE immediately (not at the boundary). All enables and direction lines go to 0.
  - cmd_valid and expiry on the same cycle: cmd_valid wins, counter clears, timeout stays 0.
  - cmd_valid while timeout=1: timeout clears next clk; the command is applied at the next boundary.
  - The counter saturates at WDT_PERIODS.
- Reset asserted mid-period or mid-dead-time: immediate return to reset state. After release, operation resumes from count 0.

Decomposition:
- Package motor_pkg:
  - dir_e {DIR_NONE, DIR_FWD, DIR_REV}
  - ch_state_e {ST_RUN, ST_DEAD}
  - localparam PWM_TOP = 254
  - function cmd_to_mag (8-bit signed -> 7-bit saturated magnitude)
- Sub-module pwm_channel, instantiated twice. It holds pending, the FSM, the dead counter, duty/dir registers and the registered enable/direction outputs. It receives count, boundary and force_coast from the top.
- Top (motor_pwm_driver) holds the prescaler, period counter and watchdog.

Test Plan (PRESCALE=0, DEADTIME_PERIODS=2, WDT_PERIODS=8):
1. Run with motor1=100, pull reset low mid-period -> all outputs 0 within the same cycle. Release -> outputs stay 0 until a cmd_valid plus a boundary.
2. cmd_valid with motor1=8'd100, motor2=8'hCE (-50) -> after the next boundary: a1=1, a2=0, enable12 high 200 of 255 ticks; a3=0, a4=1, enable34 high 100 of 255 ticks.
3. motor1 100 -> 8'h9C (-100) -> enable12=0 and a1=a2=0 for exactly 2 full periods, then a2=1 with duty 200. Motor 2 is unaffected throughout.
4. motor1=8'h80 (-128) -> duty 254: enable12 low only at count 254. motor1=8'd1 -> high only at counts 0-1. motor1=0 -> enable12=0, a1=a2=0.
5. No cmd_valid for 8 periods -> timeout=1, all enables and direction lines 0. Then cmd_valid with motor1=8'd10 -> timeout=0 next clk, duty 20 fwd from the next boundary.
6. cmd_valid coincident with a boundary, changing motor2 50 -> 60 -> that period already uses duty 120. A change mid-period -> the current period completes at the old duty.
